// File: rtl/fsm_result_pkg.sv
// Shared constants and the result entry layout for the fsm_dut result buffer.
package fsm_result_pkg;

    localparam int RESULT_DATA_WIDTH = 8;
    localparam int RESULT_DEPTH      = 4;
    localparam int RESULT_SEQ_WIDTH  = 4;

    // Queued entry at the default widths: sequence tag above the data byte.
    typedef struct packed {
        logic [RESULT_SEQ_WIDTH-1:0]  seq;
        logic [RESULT_DATA_WIDTH-1:0] data;
    } result_entry_t;

endpackage

// File: rtl/fsm_result_fifo.sv
// Small synchronous FIFO with wrap-bit pointers. A push while full is only
// taken when a pop happens in the same cycle. The head reads as zero while empty.
module fsm_result_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          wr_en;
    logic          rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_en = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign wr_en = push && (!full || rd_en);
    assign count = wptr - rptr;
    assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer update; clr empties the queue.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (!reset && !clr && wr_en) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fsm_result_buffer.sv
// Captures one fsm_dut result per valid_out rising edge, tags it with a
// sequence number and queues it for a valid/ready consumer. Also keeps
// drop statistics and a running checksum of the accepted bytes.
module fsm_result_buffer
    import fsm_result_pkg::*;
#(
    parameter int DATA_WIDTH = RESULT_DATA_WIDTH,
    parameter int DEPTH      = RESULT_DEPTH,
    parameter int SEQ_WIDTH  = RESULT_SEQ_WIDTH,
    parameter int DROP_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic [DATA_WIDTH-1:0]     fsm_data,
    input  logic                      fsm_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [SEQ_WIDTH-1:0]      out_seq,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [DROP_WIDTH-1:0]     drop_count,
    output logic [7:0]                checksum
);

    localparam int EW = SEQ_WIDTH + DATA_WIDTH;

    logic                 valid_q;
    logic [SEQ_WIDTH-1:0] seq;
    logic                 capture;
    logic                 pop_fire;
    logic                 full;
    logic                 empty;
    logic                 accept;
    logic                 drop;
    logic [EW-1:0]        head;

    assign capture   = fsm_valid && !valid_q && !clr;
    assign pop_fire  = out_ready && !empty;
    assign accept    = capture && (!full || pop_fire);
    assign drop      = capture && full && !pop_fire;
    assign out_valid = !empty;
    assign {out_seq, out_data} = head;

    fsm_result_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (capture),
        .pop   (out_ready),
        .din   ({seq, fsm_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Edge detect: valid_q tracks fsm_valid even across clr so a held level
    // does not re-trigger.
    always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= fsm_valid;
    end

    // Sequence tag advances on every capture, dropped or not.
    always_ff @(posedge clk) begin
        if (reset || clr)  seq <= '0;
        else if (capture)  seq <= seq + 1'b1;
    end

    // Drop statistics: sticky overflow and saturating counter.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    // Running mod-256 sum of the low byte of every accepted entry.
    always_ff @(posedge clk) begin
        if (reset || clr)  checksum <= '0;
        else if (accept)   checksum <= checksum + fsm_data[7:0];
    end

endmodule

// File: doc/fsm_result_buffer.md
Name: fsm_result_buffer

Overview:
Downstream stage of fsm_dut. Watches the FSM's data_out/valid_out pair and captures one result byte per COMPLETE visit, on the valid_out rising edge. Each byte is tagged with a sequence number and queued in a small FIFO. The FIFO drains through a valid/ready interface to the result consumer, and the block also keeps overflow/drop statistics and a running checksum.

Parameters:
DATA_WIDTH, 8, width of the captured FSM result (matches fsm_dut DATA_WIDTH)
DEPTH, 4, FIFO entries; power of two, >= 2
SEQ_WIDTH, 4, sequence tag width; wraps modulo 2^SEQ_WIDTH
DROP_WIDTH, 8, drop counter width; saturates

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
clr  in  1  synchronous clear of FIFO, sequence, statistics
fsm_data  in  DATA_WIDTH  fsm_dut data_out
fsm_valid  in  1  fsm_dut valid_out (held high for whole COMPLETE state)
out_data  out  DATA_WIDTH  head entry data
out_seq  out  SEQ_WIDTH  head entry sequence tag
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head this cycle
count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
overflow  out  1  sticky: a capture was dropped
drop_count  out  DROP_WIDTH  dropped captures, saturating
checksum  out  8  sum mod 256 of low 8 bits of every written byte

Behaviour:
- One clock; reset is synchronous and active-high, named clk and reset.
- Reset values: out_valid=0, out_data=0, out_seq=0, count=0, overflow=0, drop_count=0, checksum=0, seq counter=0, valid_q=0.
- Capture event: fsm_valid && !valid_q. valid_q is the fsm_valid value registered one edge earlier.
  - fsm_valid held high for N cycles gives exactly one capture.
  - fsm_valid high in the first cycle after reset counts as a capture.
- On a capture at edge k:
  - entry {seq, fsm_data} is written at edge k;
  - out_valid/count reflect it immediately after edge k, so latency is 1 edge;
  - there is no bypass, even when the FIFO is empty and out_ready is high.
- Sequence counter: increments on every capture event, accepted or dropped, so gaps are visible downstream. Wraps from 2^SEQ_WIDTH-1 to 0.
- Pop: out_valid && out_ready at an edge advances the read pointer. out_ready while empty is ignored.
- out_data/out_seq: show the head entry while non-empty. Both are 0 while empty.
- Full and capture with no pop in the same cycle:
  - the entry is dropped and overflow is set;
  - drop_count increments and saturates at all-ones;
  - checksum is unchanged.
- Full and capture with a pop in the same cycle: both happen, count stays DEPTH, and the write is accepted.
- Simultaneous capture and pop at any other fill level: count is unchanged.
- checksum adds each accepted byte mod 256 at the write edge.
- FIFO pointers: $clog2(DEPTH)+1 bits with a wrap bit. Full when the MSBs differ and the LSBs are equal; empty when the pointers are equal.
- clr at an edge:
  - empties the FIFO and zeroes seq, overflow, drop_count and checksum;
  - a capture in the same cycle is discarded and not counted;
  - valid_q still updates, so a level held across clr gives no new capture.
- Priority: reset > clr > capture/pop.
- Reset mid-operation: all state returns to reset values at that edge. Queued entries are lost.

Decomposition:
- Package fsm_result_pkg holds:
  - default constants (RESULT_DATA_WIDTH=8, RESULT_DEPTH=4, RESULT_SEQ_WIDTH=4);
  - typedef struct packed {logic [SEQ_WIDTH-1:0] seq; logic [DATA_WIDTH-1:0] data;} result_entry_t.
- Sub-module fsm_result_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised on entry width and DEPTH.
- Top level owns the edge detect, sequence counter, statistics and checksum.

Test Plan:
- Reset, then fsm_valid=1 for 3 cycles with fsm_data=8'hA5, out_ready=0 -> one entry; count=1, out_data=A5, out_seq=0, checksum=A5.
- Four 1-cycle pulses with data 01,02,03,04 (gaps between), out_ready=0 -> count=4, head out_data=01/seq=0, checksum=0A, overflow=0.
- From the full state above, a fifth pulse with data 05 and out_ready=0 -> dropped: overflow=1, drop_count=1, count=4, checksum=0A. A sixth pulse (data 06) with out_ready=1 in the same cycle -> entry {seq=5, 06} written, 01 popped, count=4.
- Drain with out_ready=1 -> seq sequence 1,2,3,5 appears (gap at 4). out_valid falls after the last pop. Empty pop is ignored.
- 17 captures with continuous out_ready=1 -> out_seq wraps 15->0. Each entry is visible one edge after its capture.
- clr asserted together with a capture pulse -> count=0, overflow=0, drop_count=0, checksum=0, seq=0, no entry. Reset mid-drain -> all outputs 0 next cycle.
